hazard_fwd_unit: RTL and testbench

// - Pipeline control for the 5-stage core. Generates the two 2-bit operand-forwarding selects

---
 rtl/hazard_fwd_unit.sv | 180 ++++++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding control for the 5-stage core: EX operand-forward selects, load-use and
// MDU stalls, branch flushes. Define HAZARD_PERF_CNT_EN to add stall/flush performance counters.
module hazard_fwd_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int MDU_TIMEOUT = 64
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  regwrite_m,
  input  logic                  regwrite_w,
  input  logic                  load_e,
  input  logic                  pcsrc_e,
  input  logic                  mdu_start_e,
  input  logic                  mdu_done,
  output logic [1:0]            fwd_a_e,
  output logic [1:0]            fwd_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_m,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
`endif
  output logic                  mdu_timeout
);

  localparam int TMO_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MDU_TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next;
  logic [TMO_W-1:0] cnt_r;
  logic [TMO_W-1:0] cnt_next;
  logic             timeout_set;
  logic             lw;

  // Memory stage wins over writeback because it holds the younger result; x0 is hard-wired zero.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                         input logic [REG_ADDR_W-1:0] dst_m,
                                         input logic                  we_m,
                                         input logic [REG_ADDR_W-1:0] dst_w,
                                         input logic                  we_w);
    logic [1:0] sel;
    if (src == REG_ADDR_W'(0)) begin
      sel = 2'b00;
    end else if (we_m && (dst_m == src)) begin
      sel = 2'b10;
    end else if (we_w && (dst_w == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign lw = load_e && (rd_e != REG_ADDR_W'(0)) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  // Pipeline control outputs: reset bubbles every stage, otherwise decoded from FSM state.
  always_comb begin
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
    end else begin
      fwd_a_e = fwd_sel(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
      fwd_b_e = fwd_sel(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
      case (state_r)
        IDLE: begin
          stall_f = lw;
          stall_d = lw;
          flush_d = pcsrc_e;
          flush_e = lw | pcsrc_e;
        end
        BUSY: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
        end
        default: begin
          flush_d = 1'b1;
          flush_e = 1'b1;
          flush_m = 1'b1;
        end
      endcase
    end
  end

  // MDU hold FSM next state; done on the same cycle as the last budget cycle is not a timeout.
  always_comb begin
    state_next  = state_r;
    cnt_next    = cnt_r;
    timeout_set = 1'b0;
    case (state_r)
      IDLE: begin
        if (mdu_start_e) begin
          state_next = BUSY;
          cnt_next   = TMO_W'(0);
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        if (mdu_done) begin
          state_next = IDLE;
        end else if (cnt_r == TMO_LAST) begin
          state_next  = IDLE;
          timeout_set = 1'b1;
        end else begin
          cnt_next = cnt_r + TMO_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = TMO_W'(0);
      end
    endcase
  end

  // FSM, timeout counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= TMO_W'(0);
      mdu_timeout <= 1'b0;
    end else begin
      state_r <= state_next;
      cnt_r   <= cnt_next;
      if (timeout_set) begin
        mdu_timeout <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Free-running wrap-around performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= CNT_W'(0);
      flush_cnt <= CNT_W'(0);
    end else begin
      if (stall_d) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (pcsrc_e) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed scenarios then randomized traffic against a
// behavioural model built from the forwarding/stall/flush rules.
module tb_hazard_fwd_unit;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       regwrite_m, regwrite_w, load_e, pcsrc_e, mdu_start_e, mdu_done;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  int unsigned m_stall_cnt, m_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int stall_seen = 0;

  // Reference state: busy flag, remaining cycle budget, sticky timeout.
  bit m_busy = 1'b0;
  int m_budget = 0;
  bit m_tmo = 1'b0;

  hazard_fwd_unit #(.REG_ADDR_W(5), .MDU_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .load_e(load_e), .pcsrc_e(pcsrc_e), .mdu_start_e(mdu_start_e), .mdu_done(mdu_done),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .mdu_timeout(mdu_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (src != 5'd0 && regwrite_m && rd_m == src) return 2'b10;
    if (src != 5'd0 && regwrite_w && rd_w == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_outputs();
    logic lw;
    lw = load_e && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
    if (rst) begin
      chk("fwd_a_rst", fwd_a_e, 2'b00);
      chk("fwd_b_rst", fwd_b_e, 2'b00);
      chk("stalls_rst", {stall_f, stall_d, stall_e}, 3'b000);
      chk("flushes_rst", {flush_d, flush_e, flush_m}, 3'b111);
    end else begin
      chk("fwd_a", fwd_a_e, exp_fwd(rs1_e));
      chk("fwd_b", fwd_b_e, exp_fwd(rs2_e));
      if (m_busy) begin
        chk("stalls_busy", {stall_f, stall_d, stall_e}, 3'b111);
        chk("flushes_busy", {flush_d, flush_e, flush_m}, 3'b001);
      end else begin
        chk("stalls_idle", {stall_f, stall_d, stall_e}, {lw, lw, 1'b0});
        chk("flushes_idle", {flush_d, flush_e, flush_m}, {pcsrc_e, lw | pcsrc_e, 1'b0});
      end
    end
    chk("mdu_timeout", mdu_timeout, m_tmo);
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall_cnt);
    chk("flush_cnt", flush_cnt, m_flush_cnt);
`endif
  endtask

  task automatic model_edge();
`ifdef HAZARD_PERF_CNT_EN
    if (!rst) begin
      if (stall_d) m_stall_cnt++;
      if (pcsrc_e) m_flush_cnt++;
    end else begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end
`endif
    if (rst) begin
      m_busy = 1'b0;
      m_tmo  = 1'b0;
    end else if (m_busy) begin
      if (mdu_done) begin
        m_busy = 1'b0;
      end else begin
        m_budget--;
        if (m_budget == 0) begin
          m_busy = 1'b0;
          m_tmo  = 1'b1;
        end
      end
    end else if (mdu_start_e) begin
      m_busy   = 1'b1;
      m_budget = TMO;
    end
  endtask

  // Inputs are held from one falling edge to the next; outputs checked 1 time unit after it.
  task automatic cycle();
    #1;
    check_outputs();
    if (stall_e) stall_seen++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
    rd_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0;
    regwrite_m = 1'b0; regwrite_w = 1'b0; load_e = 1'b0;
    pcsrc_e = 1'b0; mdu_start_e = 1'b0; mdu_done = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    // Reset masks a would-be forward and load-use.
    rd_m = 5'd5; regwrite_m = 1'b1; rs1_e = 5'd5; load_e = 1'b1; rd_e = 5'd3; rs1_d = 5'd3;
    #1;
    chk("reset_fwd_a", fwd_a_e, 2'b00);
    chk("reset_flush_all", {flush_d, flush_e, flush_m}, 3'b111);
    cycle();
    cycle();
    rst = 1'b0;
    clear_inputs();
    cycle();

    // M has priority over W; W used once M is not writing.
    rd_m = 5'd5; regwrite_m = 1'b1; rd_w = 5'd5; regwrite_w = 1'b1; rs1_e = 5'd5;
    #1 chk("fwd_m_priority", fwd_a_e, 2'b10);
    cycle();
    regwrite_m = 1'b0;
    #1 chk("fwd_w_only", fwd_a_e, 2'b01);
    cycle();
    clear_inputs();
    rs2_e = 5'd0; rd_m = 5'd0; regwrite_m = 1'b1;
    #1 chk("fwd_x0", fwd_b_e, 2'b00);
    cycle();

    // Load-use: one stall cycle, then the load has moved on to M.
    clear_inputs();
    load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
    #1 chk("lu_stall", {stall_f, stall_d, flush_e}, 3'b111);
    cycle();
    clear_inputs();
    rd_m = 5'd7; rs2_d = 5'd7;
    #1 chk("lu_release", {stall_f, stall_d, flush_e}, 3'b000);
    cycle();

    // MDU with done on the 5th busy cycle: five stall cycles.
    mdu_start_e = 1'b1;
    cycle();
    mdu_start_e = 1'b0;
    stall_seen = 0;
    for (int i = 0; i < 8; i++) begin
      mdu_done = (i == 4);
      cycle();
    end
    mdu_done = 1'b0;
    chk("mdu_stall_cycles", stall_seen, 5);

    // MDU with no done: TMO stall cycles then the sticky error.
    mdu_start_e = 1'b1;
    cycle();
    mdu_start_e = 1'b0;
    stall_seen = 0;
    for (int i = 0; i < TMO + 4; i++) cycle();
    chk("tmo_stall_cycles", stall_seen, TMO);
    chk("tmo_flag", mdu_timeout, 1'b1);

    // Reset mid-busy abandons the MDU and clears the error.
    mdu_start_e = 1'b1;
    cycle();
    mdu_start_e = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1 chk("rst_mid_busy_stall_e", stall_e, 1'b0);
    chk("rst_clears_tmo", mdu_timeout, 1'b0);
    cycle();

    // Branch taken together with load-use.
    load_e = 1'b1; rd_e = 5'd9; rs1_d = 5'd9; pcsrc_e = 1'b1;
    #1 chk("br_lw_flush", {flush_d, flush_e, stall_d}, 3'b111);
    cycle();
    clear_inputs();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7));
      rs1_e = 5'($urandom_range(0, 7)); rs2_e = 5'($urandom_range(0, 7));
      rd_e  = 5'($urandom_range(0, 7)); rd_m  = 5'($urandom_range(0, 7));
      rd_w  = 5'($urandom_range(0, 7));
      regwrite_m  = 1'($urandom_range(0, 1));
      regwrite_w  = 1'($urandom_range(0, 1));
      load_e      = 1'($urandom_range(0, 3) == 0);
      pcsrc_e     = 1'($urandom_range(0, 7) == 0);
      mdu_start_e = 1'($urandom_range(0, 11) == 0);
      mdu_done    = 1'($urandom_range(0, 9) == 0);
      rst         = 1'($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
